// File: rtl/pps_pkg.sv
// Shared types and constants for the PPS period measurement path.
// Timeout default is 1.5 s of the 27 MHz system clock.
package pps_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } state_t;

   localparam int DEF_CNT_WIDTH      = 32;
   localparam int CLK_FREQ_HZ        = 27_000_000;
   localparam int DEF_TIMEOUT_CYCLES = CLK_FREQ_HZ + CLK_FREQ_HZ / 2;

endpackage

// File: rtl/pps_period_counter.sv
// Measures clk cycles between PPS pulses; result one cycle after the closing pulse.
// No backpressure: an unread result is overwritten and flagged as overrun.
module pps_period_counter
   import pps_pkg::*;
#(
   parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int PCNT_WIDTH     = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  pps_pulse,
   input  logic                  clear,
   input  logic                  rd_ack,
   output logic [CNT_WIDTH-1:0]  period,
   output logic                  period_valid,
   output logic                  overrun,
   output logic                  missing,
   output logic                  armed,
   output logic [PCNT_WIDTH-1:0] pulse_count
);

   localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

   state_t                  state_q, state_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]    period_q, period_d;
   logic                    period_valid_q, period_valid_d;
   logic                    overrun_q, overrun_d;
   logic                    missing_q, missing_d;
   logic [PCNT_WIDTH-1:0]   pulse_count_q, pulse_count_d;
   logic                    new_result;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      period_d       = period_q;
      period_valid_d = period_valid_q;
      overrun_d      = overrun_q;
      missing_d      = missing_q;
      pulse_count_d  = pulse_count_q;
      new_result     = 1'b0;

      if (clear) begin
         state_d        = IDLE;
         cnt_d          = '0;
         period_d       = '0;
         period_valid_d = 1'b0;
         overrun_d      = 1'b0;
         missing_d      = 1'b0;
         pulse_count_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pps_pulse) begin
                  state_d       = ARMED;
                  cnt_d         = CNT_WIDTH'(1);
                  pulse_count_d = pulse_count_q + PCNT_WIDTH'(1);
               end
            end
            ARMED: begin
               // A pulse landing on the timeout cycle still closes a valid period.
               if (pps_pulse) begin
                  period_d      = cnt_q;
                  new_result    = 1'b1;
                  cnt_d         = CNT_WIDTH'(1);
                  pulse_count_d = pulse_count_q + PCNT_WIDTH'(1);
               end else if (cnt_q == TIMEOUT_VAL) begin
                  state_d   = IDLE;
                  cnt_d     = '0;
                  missing_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase

         if (new_result) begin
            period_valid_d = 1'b1;
            if (period_valid_q && !rd_ack) begin
               overrun_d = 1'b1;
            end
         end else if (rd_ack) begin
            period_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
         missing_q      <= 1'b0;
         pulse_count_q  <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         overrun_q      <= overrun_d;
         missing_q      <= missing_d;
         pulse_count_q  <= pulse_count_d;
      end
   end

   assign period       = period_q;
   assign period_valid = period_valid_q;
   assign overrun      = overrun_q;
   assign missing      = missing_q;
   assign armed        = (state_q == ARMED);
   assign pulse_count  = pulse_count_q;

endmodule

// File: tb/tb_pps_period_counter.sv
// Directed bench for pps_period_counter with a 20-cycle timeout and 4-bit pulse counter.
module tb_pps_period_counter;

   localparam int CW = 8;
   localparam int TO = 20;
   localparam int PW = 4;

   logic          clk;
   logic          reset_n;
   logic          pps_pulse;
   logic          clear;
   logic          rd_ack;
   logic [CW-1:0] period;
   logic          period_valid;
   logic          overrun;
   logic          missing;
   logic          armed;
   logic [PW-1:0] pulse_count;

   int n_checks = 0;
   int n_fail   = 0;

   pps_period_counter #(
      .CNT_WIDTH     (CW),
      .TIMEOUT_CYCLES(TO),
      .PCNT_WIDTH    (PW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pps_pulse   (pps_pulse),
      .clear       (clear),
      .rd_ack      (rd_ack),
      .period      (period),
      .period_valid(period_valid),
      .overrun     (overrun),
      .missing     (missing),
      .armed       (armed),
      .pulse_count (pulse_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse();
      pps_pulse = 1'b1;
      tick();
      pps_pulse = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_period"}, 32'(period), 0);
      check({tag, "_valid"}, 32'(period_valid), 0);
      check({tag, "_overrun"}, 32'(overrun), 0);
      check({tag, "_missing"}, 32'(missing), 0);
      check({tag, "_armed"}, 32'(armed), 0);
      check({tag, "_pcnt"}, 32'(pulse_count), 0);
   endtask

   initial begin
      reset_n   = 1'b0;
      pps_pulse = 1'b0;
      clear     = 1'b0;
      rd_ack    = 1'b0;
      #22;
      check_all_zero("reset");
      reset_n = 1'b1;

      // 1: pulses 10 cycles apart with rd_ack held high
      rd_ack = 1'b1;
      idle(4);
      pulse();
      check("t1_armed", 32'(armed), 1);
      check("t1_pcnt1", 32'(pulse_count), 1);
      check("t1_novalid", 32'(period_valid), 0);
      idle(9);
      pulse();
      check("t1_period_a", 32'(period), 10);
      check("t1_valid_a", 32'(period_valid), 1);
      idle(9);
      pulse();
      check("t1_period_b", 32'(period), 10);
      check("t1_valid_b", 32'(period_valid), 1);
      check("t1_pcnt3", 32'(pulse_count), 3);
      check("t1_overrun", 32'(overrun), 0);
      check("t1_missing", 32'(missing), 0);
      check("t1_armed_b", 32'(armed), 1);
      rd_ack = 1'b0;

      // 2: timeout then re-arm
      do_clear();
      pulse();
      idle(19);
      check("t2_still_armed", 32'(armed), 1);
      check("t2_no_missing_yet", 32'(missing), 0);
      idle(1);
      check("t2_disarmed", 32'(armed), 0);
      check("t2_missing", 32'(missing), 1);
      check("t2_valid0", 32'(period_valid), 0);
      idle(4);
      pulse();
      check("t2_rearmed", 32'(armed), 1);
      check("t2_rearm_noresult", 32'(period_valid), 0);
      idle(6);
      pulse();
      check("t2_period7", 32'(period), 7);
      check("t2_valid1", 32'(period_valid), 1);
      check("t2_missing_sticky", 32'(missing), 1);

      // 3: pulse coincides with timeout
      do_clear();
      pulse();
      idle(19);
      pulse();
      check("t3_period20", 32'(period), 20);
      check("t3_missing0", 32'(missing), 0);
      check("t3_armed", 32'(armed), 1);
      check("t3_valid", 32'(period_valid), 1);

      // 4: overrun without rd_ack
      do_clear();
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      check("t4_ack_noeffect_v", 32'(period_valid), 0);
      check("t4_ack_noeffect_o", 32'(overrun), 0);
      pulse();
      idle(7);
      pulse();
      check("t4_first_period", 32'(period), 8);
      check("t4_first_overrun", 32'(overrun), 0);
      idle(7);
      pulse();
      check("t4_period8", 32'(period), 8);
      check("t4_overrun1", 32'(overrun), 1);
      // rd_ack coincident with a new result
      do_clear();
      pulse();
      idle(7);
      pulse();
      idle(4);
      rd_ack = 1'b1;
      pulse();
      rd_ack = 1'b0;
      check("t4_coinc_period", 32'(period), 5);
      check("t4_coinc_valid", 32'(period_valid), 1);
      check("t4_coinc_overrun", 32'(overrun), 0);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      check("t4_ack_clears", 32'(period_valid), 0);

      // 5: clear with coincident pulse after flags are set
      do_clear();
      pulse();
      idle(20);
      pulse();
      idle(4);
      pulse();
      idle(2);
      pulse();
      check("t5_pre_missing", 32'(missing), 1);
      check("t5_pre_overrun", 32'(overrun), 1);
      idle(3);
      clear     = 1'b1;
      pps_pulse = 1'b1;
      tick();
      clear     = 1'b0;
      pps_pulse = 1'b0;
      check_all_zero("t5_clear");
      pulse();
      check("t5_after_armed", 32'(armed), 1);
      check("t5_after_pcnt", 32'(pulse_count), 1);
      check("t5_after_valid", 32'(period_valid), 0);

      // 6: asynchronous reset mid-count, then counter wrap
      idle(4);
      pulse();
      check("t6_pre_period", 32'(period), 5);
      idle(3);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("t6_async");
      #2;
      reset_n = 1'b1;
      pps_pulse = 1'b1;
      idle(17);
      pps_pulse = 1'b0;
      check("t6_pcnt_wrap", 32'(pulse_count), 1);
      check("t6_period1", 32'(period), 1);
      check("t6_overrun", 32'(overrun), 1);
      check("t6_armed", 32'(armed), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
